flit_injector: RTL and testbench
================================

FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 SHALL have parameters, one per line:
- X_NODE_NUM, 4, mesh columns
- Y_NODE_NUM, 4, mesh rows
- SW_X_ADDR, 2, own router X
- SW_Y_ADDR, 1, own router Y
- FLIT_WIDTH, 32, flit bits including 2-bit type
- BUF_DEPTH, 4, router input-buffer depth (initial credits)
- LEN_WIDTH, 4, payload-length field width
REQ-002 SHALL have ports, one per line, with one clock and an asynchronous, active-high reset:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  packet request
- req_ready  out  1  request accepted
- dest_x  in  log2(X_NODE_NUM)  destination X
- dest_y  in  log2(Y_NODE_NUM)  destination Y
- pkt_len  in  LEN_WIDTH  payload flits (1..2^LEN_WIDTH-1)
- data_in  in  FLIT_WIDTH-2  payload word
- data_valid  in  1  payload word present
- data_ready  out  1  payload word consumed
- flit_out  out  FLIT_WIDTH  flit to local router port
- flit_wr  out  1  flit_out valid this cycle
- credit_in  in  1  one buffer slot freed
- len_err  out  1  one-cycle pulse, zero-length request dropped

Function
REQ-003 SHALL use flit type field flit_out[FLIT_WIDTH-1:FLIT_WIDTH-2]: header 2'b10, body 2'b00, tail 2'b01.
REQ-004 SHALL build the header payload, LSB-justified: {port[2:0], dest_x, dest_y, SW_X_ADDR, SW_Y_ADDR}, upper bits zero.
REQ-005 SHALL compute header port by XY at the source: xd>xc EAST(1); xd<xc WEST(3); xd==xc and yd>yc SOUTH(4); yd<yc NORTH(2); equal LOCAL(0).
REQ-006 SHALL implement FSM IDLE, HDR, BODY; reset state IDLE.
REQ-007 IDLE: req_ready=1; req_valid with pkt_len!=0 latches dest_x, dest_y, pkt_len, go HDR next cycle.
REQ-008 IDLE: req_valid with pkt_len==0 SHALL pulse len_err for one cycle, latch nothing, and stay in IDLE.
REQ-009 HDR: when credit count>0, flit_wr=1 with header flit, go BODY; otherwise hold in HDR with flit_wr=0.
REQ-010 BODY: data_ready=(credit count>0); a transfer occurs when data_ready and data_valid; flit_wr=1 with data_in in payload.
REQ-011 Transferred flit SHALL be tail if it is the pkt_len-th payload flit, else body; after tail go IDLE.
REQ-012 req_ready SHALL be 0 in HDR and BODY; data_ready SHALL be 0 outside BODY.
REQ-013 Credit counter width log2(BUF_DEPTH+1); +1 per credit_in, -1 per flit_wr; both together leave it unchanged.
REQ-014 Counter SHALL never exceed BUF_DEPTH; credit_in at BUF_DEPTH without flit_wr is ignored.
REQ-015 flit_out and flit_wr SHALL be registered: one-cycle latency from the qualifying edge; flit_out holds its last value when flit_wr=0.
REQ-016 Minimum packet occupancy: 1 cycle IDLE accept + 1 header + pkt_len body cycles; back-to-back request accepted in the cycle after tail.

Reset
REQ-017 reset SHALL asynchronously force state IDLE, credit=BUF_DEPTH, flit_wr=0, flit_out=0, len_err=0, data_ready=0, and drop the latched request.
REQ-018 Reset mid-packet SHALL abandon the packet with no tail emitted; first cycle after release: req_ready=1.

Verification
REQ-019 Own (2,1), dest (3,3), pkt_len 2, credits full, data_valid held -> header port EAST, dest 3/3, src 2/1; body; tail; flit_wr 3 consecutive cycles.
REQ-020 Dest (2,0); dest (2,3); dest (2,1) -> header port NORTH(2), SOUTH(4), LOCAL(0) respectively.
REQ-021 BUF_DEPTH 4, no credit_in, pkt_len 6 -> exactly 4 flits, then stall; one credit_in pulse -> exactly one more flit.
REQ-022 Credit_in asserted every cycle during pkt_len 5 -> counter stays at 4, no stall, tail on 6th flit.
REQ-023 pkt_len 0 with req_valid -> len_err single pulse, no flit_wr, req_ready stays 1.
REQ-024 reset asserted after header of pkt_len 3 -> flit_wr=0 immediately, credit=BUF_DEPTH, next packet starts with header.

Source files
------------

// File: rtl/flit_injector.sv
// Network-interface flit injector: turns a packet request plus a stream of payload
// words into header/body/tail flits for the local router port, gated by credits.
module flit_injector #(
  parameter int X_NODE_NUM = 4,
  parameter int Y_NODE_NUM = 4,
  parameter int SW_X_ADDR  = 2,
  parameter int SW_Y_ADDR  = 1,
  parameter int FLIT_WIDTH = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [$clog2(X_NODE_NUM)-1:0] dest_x,
  input  logic [$clog2(Y_NODE_NUM)-1:0] dest_y,
  input  logic [LEN_WIDTH-1:0]          pkt_len,
  input  logic [FLIT_WIDTH-3:0]         data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic [FLIT_WIDTH-1:0]         flit_out,
  output logic                          flit_wr,
  input  logic                          credit_in,
  output logic                          len_err
);

  localparam int XW = $clog2(X_NODE_NUM);
  localparam int YW = $clog2(Y_NODE_NUM);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = FLIT_WIDTH - 2;

  localparam logic [XW-1:0] SX       = XW'(SW_X_ADDR);
  localparam logic [YW-1:0] SY       = YW'(SW_Y_ADDR);
  localparam logic [CW-1:0] CRED_MAX = CW'(BUF_DEPTH);

  localparam logic [1:0] TYPE_HDR  = 2'b10;
  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b01;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         dx_q, dx_d;
  logic [YW-1:0]         dy_q, dy_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  wr_q, wr_d;
  logic                  len_err_q, len_err_d;

  logic                  has_credit;
  logic                  send;
  logic [2:0]            port;
  logic [PW-1:0]         hdr_payload;

  // Dimension-ordered (X first, then Y) output port chosen once at the source.
  always_comb begin
    port = 3'd0;
    if (dx_q > SX)      port = 3'd1;
    else if (dx_q < SX) port = 3'd3;
    else if (dy_q > SY) port = 3'd4;
    else if (dy_q < SY) port = 3'd2;
    hdr_payload = PW'({port, dx_q, dy_q, SX, SY});
  end

  always_comb begin
    has_credit = (credit_q != '0);
    req_ready  = (state_q == IDLE);
    data_ready = (state_q == BODY) && has_credit;

    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    flit_d    = flit_q;
    len_err_d = 1'b0;
    send      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (pkt_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            dx_d    = dest_x;
            dy_d    = dest_y;
            len_d   = pkt_len;
            cnt_d   = '0;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (has_credit) begin
          send    = 1'b1;
          flit_d  = {TYPE_HDR, hdr_payload};
          state_d = BODY;
        end
      end
      BODY: begin
        if (has_credit && data_valid) begin
          send  = 1'b1;
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            flit_d  = {TYPE_TAIL, data_in};
            state_d = IDLE;
          end else begin
            flit_d  = {TYPE_BODY, data_in};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d = send;

    // A returned credit and a launched flit in the same cycle cancel out.
    credit_d = credit_q;
    if (credit_in && !send && (credit_q != CRED_MAX)) credit_d = credit_q + CW'(1);
    else if (!credit_in && send)                      credit_d = credit_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dx_q      <= '0;
      dy_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      credit_q  <= CRED_MAX;
      flit_q    <= '0;
      wr_q      <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      credit_q  <= credit_d;
      flit_q    <= flit_d;
      wr_q      <= wr_d;
      len_err_q <= len_err_d;
    end
  end

  assign flit_out = flit_q;
  assign flit_wr  = wr_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_flit_injector.sv
// Randomized bench for flit_injector: a packet-level model predicts every flit,
// the buffer occupancy of the attached router and the req_ready/len_err behaviour.
module tb_flit_injector;

  localparam int XN    = 4;
  localparam int YN    = 4;
  localparam int SXA   = 2;
  localparam int SYA   = 1;
  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    dest_x;
  logic [1:0]    dest_y;
  logic [LW-1:0] pkt_len;
  logic [FW-3:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [FW-1:0] flit_out;
  logic          flit_wr;
  logic          credit_in;
  logic          len_err;

  flit_injector #(
    .X_NODE_NUM(XN), .Y_NODE_NUM(YN), .SW_X_ADDR(SXA), .SW_Y_ADDR(SYA),
    .FLIT_WIDTH(FW), .BUF_DEPTH(DEPTH), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .dest_x(dest_x), .dest_y(dest_y), .pkt_len(pkt_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .flit_out(flit_out), .flit_wr(flit_wr),
    .credit_in(credit_in), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-3:0] pay_q[$];
  logic [FW-3:0] stage_q[$];
  int            occ = 0;
  bit            in_flight = 0;
  bit            exp_len_err = 0;
  bit            hs_data = 0;
  bit            req_taken = 0;
  int            cyc = 0;
  int            flits_seen = 0;
  int            hdr_cyc = 0;
  int            tail_cyc = 0;
  logic [FW-1:0] last_hdr = '0;
  int            credit_mode = 1;
  int            gap_pct = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Expected header flit derived directly from XY routing rules.
  function automatic logic [FW-1:0] hdr_flit(input int dx, input int dy);
    int port;
    if (dx > SXA)      port = 1;
    else if (dx < SXA) port = 3;
    else if (dy > SYA) port = 4;
    else if (dy < SYA) port = 2;
    else               port = 0;
    return {2'b10, 30'(port * 256 + dx * 64 + dy * 16 + SXA * 4 + SYA)};
  endfunction

  task automatic step();
    logic [FW-1:0] want;
    @(negedge clk);
    cyc++;
    if (flit_wr) begin
      if (exp_q.size() == 0) begin
        checkOutput("flit_wr_unexpected", 32'(flit_wr), 32'd0);
      end else begin
        want = exp_q.pop_front();
        checkOutput("flit", flit_out, want);
        if (want[FW-1:FW-2] == 2'b10) begin
          hdr_cyc  = cyc;
          last_hdr = flit_out;
        end
        if (want[FW-1:FW-2] == 2'b01) begin
          tail_cyc  = cyc;
          in_flight = 0;
        end
      end
      flits_seen++;
      occ++;
      checkOutput("buffer_overrun", 32'(occ > DEPTH), 32'd0);
    end
    checkOutput("len_err", 32'(len_err), 32'(exp_len_err));
    checkOutput("req_ready", 32'(req_ready), 32'(!in_flight));
    if (!in_flight) checkOutput("data_ready_idle", 32'(data_ready), 32'd0);
    exp_len_err = 0;
    if (req_valid && req_ready) begin
      req_taken = 1;
      if (pkt_len == '0) begin
        exp_len_err = 1;
      end else begin
        in_flight = 1;
        exp_q.push_back(hdr_flit(int'(dest_x), int'(dest_y)));
        for (int i = 0; i < int'(pkt_len); i++) begin
          exp_q.push_back({(i == int'(pkt_len) - 1) ? 2'b01 : 2'b00, stage_q[i]});
          pay_q.push_back(stage_q[i]);
        end
      end
    end
    hs_data = data_valid && data_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    if (hs_data && pay_q.size() > 0) pay_q.delete(0);
    hs_data = 0;
    if (req_taken) begin
      req_valid = 1'b0;
      req_taken = 0;
    end
    if (pay_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      data_valid = 1'b1;
      data_in    = pay_q[0];
    end else begin
      data_valid = 1'b0;
      data_in    = 30'($urandom);
    end
    case (credit_mode)
      0:       credit_in = 1'b0;
      1:       credit_in = (occ > 0) && ($urandom_range(0, 1) == 1);
      2:       credit_in = 1'b1;
      default: begin
        credit_in   = 1'b1;
        credit_mode = 0;
      end
    endcase
    if (credit_in && occ > 0) occ--;
  endtask

  task automatic cycle();
    step();
    drive();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((in_flight || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    checkOutput("packet_timeout", 32'(in_flight), 32'd0);
  endtask

  task automatic applyStimulus(input int dx, input int dy, input int len);
    int n = 0;
    wait_idle(400);
    stage_q.delete();
    for (int i = 0; i < len; i++) stage_q.push_back(30'($urandom));
    dest_x    = 2'(dx);
    dest_y    = 2'(dy);
    pkt_len   = LW'(len);
    req_valid = 1'b1;
    while (req_valid && n < 10) begin
      cycle();
      n++;
    end
    if (req_valid) begin
      checkOutput("req_accept_timeout", 32'(req_valid), 32'd0);
      req_valid = 1'b0;
    end
  endtask

  task automatic restore_credits();
    int n = 0;
    credit_mode = 1;
    while (occ > 0 && n < 100) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    dest_x     = '0;
    dest_y     = '0;
    pkt_len    = '0;
    data_in    = '0;
    data_valid = 1'b0;
    credit_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_flit_wr", 32'(flit_wr), 32'd0);
    checkOutput("reset_flit_out", flit_out, 32'd0);
    checkOutput("reset_len_err", 32'(len_err), 32'd0);
    checkOutput("reset_data_ready", 32'(data_ready), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    cycle();

    // Full-credit packet east with a continuous payload stream.
    credit_mode = 1;
    gap_pct     = 0;
    applyStimulus(3, 3, 2);
    wait_idle(100);
    checkOutput("east_port", 32'(last_hdr[10:8]), 32'd1);
    checkOutput("east_span", 32'(tail_cyc - hdr_cyc), 32'd2);

    applyStimulus(2, 0, 1);
    wait_idle(100);
    checkOutput("north_port", 32'(last_hdr[10:8]), 32'd2);
    applyStimulus(2, 3, 1);
    wait_idle(100);
    checkOutput("south_port", 32'(last_hdr[10:8]), 32'd4);
    applyStimulus(2, 1, 1);
    wait_idle(100);
    checkOutput("local_port", 32'(last_hdr[10:8]), 32'd0);

    // Credit starvation: only BUF_DEPTH flits leave, then one per returned credit.
    restore_credits();
    credit_mode = 0;
    base = flits_seen;
    applyStimulus(1, 2, 6);
    repeat (20) cycle();
    checkOutput("stall_count", 32'(flits_seen - base), 32'd4);
    credit_mode = 3;
    repeat (10) cycle();
    checkOutput("one_credit_count", 32'(flits_seen - base), 32'd5);
    credit_mode = 1;
    wait_idle(200);

    // Credits returned every cycle keep the counter full: no stall at all.
    restore_credits();
    credit_mode = 2;
    applyStimulus(0, 1, 5);
    wait_idle(100);
    checkOutput("no_stall_span", 32'(tail_cyc - hdr_cyc), 32'd5);

    // Zero-length request is dropped with a len_err pulse.
    credit_mode = 1;
    base = flits_seen;
    applyStimulus(3, 2, 0);
    repeat (5) cycle();
    checkOutput("zero_len_flits", 32'(flits_seen - base), 32'd0);

    // Reset in the middle of a packet.
    restore_credits();
    credit_mode = 0;
    base = flits_seen;
    applyStimulus(3, 0, 3);
    n = 0;
    while (flits_seen == base && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("mid_reset_header_seen", 32'(flits_seen - base), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_flit_wr", 32'(flit_wr), 32'd0);
    checkOutput("mid_reset_flit_out", flit_out, 32'd0);
    checkOutput("mid_reset_data_ready", 32'(data_ready), 32'd0);
    exp_q.delete();
    pay_q.delete();
    in_flight   = 0;
    occ         = 0;
    exp_len_err = 0;
    hs_data     = 0;
    req_taken   = 0;
    req_valid   = 1'b0;
    data_valid  = 1'b0;
    credit_in   = 1'b0;
    #1;
    reset = 1'b0;
    cycle();
    applyStimulus(1, 2, 3);
    wait_idle(100);
    checkOutput("post_reset_span", 32'(tail_cyc - hdr_cyc), 32'd3);

    // Randomized traffic with bubbles and randomly returned credits.
    credit_mode = 1;
    gap_pct     = 30;
    for (int p = 0; p < 25; p++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), len);
    end
    wait_idle(400);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
